// File: rtl/cpu_loader_pkg.sv
// Shared constants and types for the byte-stream program/data loader.
package cpu_loader_pkg;

   localparam logic [7:0] CmdLoadI  = 8'hA1;
   localparam logic [7:0] CmdLoadD  = 8'hA2;
   localparam logic [7:0] CmdRun    = 8'hA3;
   localparam logic [7:0] CmdHalt   = 8'hA4;
   localparam logic [7:0] CmdClrErr = 8'hA5;

   localparam int unsigned HdrLen = 4;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StData,
      StWrite
   } state_e;

endpackage

// File: rtl/cpu_loader_if.sv
// Byte-stream input, imem/dmem write ports and status of the loader.
interface cpu_loader_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;

   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;

   logic        cpu_enable;
   logic        busy;
   logic        err;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready,
      output addr_ext, wen_ext, ren_ext, wdata_ext,
      output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
      output cpu_enable, busy, err
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready,
      input  addr_ext, wen_ext, ren_ext, wdata_ext,
      input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
      input  cpu_enable, busy, err
   );

endinterface

// File: rtl/loader_shift_reg.sv
// 64-bit little-endian byte assembler: bytes enter at the top and move down,
// so after 4 bytes a 32-bit word sits in [63:32] and after 8 the full word.
module loader_shift_reg (
   input  logic        clk,
   input  logic        arst,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [63:0] nxt_o
);

   logic [63:0] q_q, q_d;

   // load starts a fresh word so no byte of a previous word can leak in
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (load_i) begin
         q_d = {byte_i, 56'b0};
      end else if (shift_i) begin
         q_d = {byte_i, q_q[63:8]};
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // next value lets the FSM capture a word on the edge its last byte arrives
   assign nxt_o = q_d;

endmodule

// File: rtl/cpu_loader.sv
// Command-driven loader: streams words into instruction or data memory and
// controls the CPU enable.
module cpu_loader
   import cpu_loader_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 512,
   parameter int unsigned DMEM_WORDS = 1024
) (
   input logic        clk,
   input logic        arst,
   cpu_loader_if.master bus
);

   localparam logic [2:0] HdrLast = 3'(HdrLen - 1);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  byte_cnt_q;
   logic [16:0] widx_q;
   logic        dmem_q;
   logic        cpu_en_q;
   logic        err_q;
   logic        rdy_q;
   logic        wen_q;
   logic        wen2_q;
   logic [63:0] addr_q;
   logic [31:0] wdata_q;
   logic [63:0] addr2_q;
   logic [63:0] wdata2_q;

   logic        accept;
   logic        in_stream;
   logic        sr_clr, sr_load, sr_shift;
   logic [63:0] sr_nxt;
   logic        word_last;
   logic        in_range;

   assign accept    = bus.rx_valid & rdy_q;
   assign in_stream = (state_q == StHdr) || (state_q == StData);
   assign sr_clr    = accept & (state_q == StIdle);
   assign sr_load   = accept & in_stream & (byte_cnt_q == 3'd0);
   assign sr_shift  = accept & in_stream & (byte_cnt_q != 3'd0);
   assign word_last = byte_cnt_q == (dmem_q ? 3'd7 : 3'd3);
   assign in_range  = dmem_q ? ({15'b0, widx_q} < DMEM_WORDS)
                             : ({15'b0, widx_q} < IMEM_WORDS);

   loader_shift_reg u_shift_reg (
      .clk     (clk),
      .arst    (arst),
      .clr_i   (sr_clr),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .byte_i  (bus.rx_data),
      .nxt_o   (sr_nxt)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         byte_cnt_q <= '0;
         widx_q     <= '0;
         dmem_q     <= 1'b0;
         cpu_en_q   <= 1'b0;
         err_q      <= 1'b0;
         rdy_q      <= 1'b0;
         wen_q      <= 1'b0;
         wen2_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         addr2_q    <= '0;
         wdata2_q   <= '0;
      end else begin
         rdy_q  <= 1'b1;
         wen_q  <= 1'b0;
         wen2_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  byte_cnt_q <= '0;
                  case (bus.rx_data)
                     CmdLoadI: begin
                        state_q  <= StHdr;
                        dmem_q   <= 1'b0;
                        cpu_en_q <= 1'b0;
                     end
                     CmdLoadD: begin
                        state_q  <= StHdr;
                        dmem_q   <= 1'b1;
                        cpu_en_q <= 1'b0;
                     end
                     CmdRun:    cpu_en_q <= 1'b1;
                     CmdHalt:   cpu_en_q <= 1'b0;
                     CmdClrErr: err_q    <= 1'b0;
                     default:   err_q    <= 1'b1;
                  endcase
               end
            end
            StHdr: begin
               if (accept) begin
                  if (byte_cnt_q == HdrLast) begin
                     // header word is {S[15:0], N[15:0]} in sr_nxt[63:32]
                     byte_cnt_q <= '0;
                     cnt_q      <= sr_nxt[47:32];
                     widx_q     <= {1'b0, sr_nxt[63:48]};
                     state_q    <= (sr_nxt[47:32] == 16'd0) ? StIdle : StData;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                  end
               end
            end
            StData: begin
               if (accept) begin
                  if (word_last) begin
                     byte_cnt_q <= '0;
                     state_q    <= StWrite;
                     rdy_q      <= 1'b0;
                     if (!in_range) begin
                        err_q <= 1'b1;
                     end else if (dmem_q) begin
                        wen2_q   <= 1'b1;
                        addr2_q  <= {44'b0, widx_q, 3'b0};
                        wdata2_q <= sr_nxt;
                     end else begin
                        wen_q   <= 1'b1;
                        addr_q  <= {45'b0, widx_q, 2'b0};
                        wdata_q <= sr_nxt[63:32];
                     end
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 3'd1;
                  end
               end
            end
            StWrite: begin
               cnt_q   <= cnt_q - 16'd1;
               widx_q  <= widx_q + 17'd1;
               state_q <= (cnt_q == 16'd1) ? StIdle : StData;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rx_ready    = rdy_q;
   assign bus.addr_ext    = addr_q;
   assign bus.wen_ext     = wen_q;
   assign bus.ren_ext     = 1'b0;
   assign bus.wdata_ext   = wdata_q;
   assign bus.addr_ext_2  = addr2_q;
   assign bus.wen_ext_2   = wen2_q;
   assign bus.ren_ext_2   = 1'b0;
   assign bus.wdata_ext_2 = wdata2_q;
   assign bus.cpu_enable  = cpu_en_q;
   assign bus.busy        = state_q != StIdle;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: load, run/halt, error and reset scenarios.
module tb_cpu_loader;

   logic clk = 1'b0;
   logic arst;

   always #5 clk = ~clk;

   cpu_loader_if bus ();

   cpu_loader #(
      .IMEM_WORDS (512),
      .DMEM_WORDS (1024)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   int          imem_n = 0;
   int          dmem_n = 0;
   int          viol   = 0;
   logic [63:0] i_addr [8];
   logic [31:0] i_data [8];
   logic [63:0] d_addr [8];
   logic [63:0] d_data [8];

   // write log plus strobe-exclusivity and rx_ready-low-while-writing checks
   always @(negedge clk) begin
      if (!arst) begin
         if (bus.wen_ext) begin
            if (imem_n < 8) begin
               i_addr[imem_n] = bus.addr_ext;
               i_data[imem_n] = bus.wdata_ext;
            end
            imem_n++;
         end
         if (bus.wen_ext_2) begin
            if (dmem_n < 8) begin
               d_addr[dmem_n] = bus.addr_ext_2;
               d_data[dmem_n] = bus.wdata_ext_2;
            end
            dmem_n++;
         end
         if (bus.wen_ext && bus.wen_ext_2) viol++;
         if ((bus.wen_ext || bus.wen_ext_2) && bus.rx_ready) viol++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (bus.rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("rx_ready_wait", {63'b0, bus.rx_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] d2 [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
   int base_i;
   int base_d;

   initial begin
      arst         = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", {63'b0, bus.rx_ready}, 64'd0);
      chk("rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_err", {63'b0, bus.err}, 64'd0);
      chk("rst_cpu_en", {63'b0, bus.cpu_enable}, 64'd0);
      chk("rst_wen", {62'b0, bus.wen_ext, bus.wen_ext_2}, 64'd0);
      chk("rst_addr", bus.addr_ext, 64'd0);
      chk("rst_ren", {62'b0, bus.ren_ext, bus.ren_ext_2}, 64'd0);
      @(negedge clk);
      arst = 1'b0;
      tick();
      chk("rdy_after_rst", {63'b0, bus.rx_ready}, 64'd1);

      // single imem word: N=1, S=2
      base_i = imem_n;
      send(8'hA1);
      chk("loadi_busy", {63'b0, bus.busy}, 64'd1);
      send(8'h01); send(8'h00); send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00);
      chk("t1_no_early_wen", {63'b0, bus.wen_ext}, 64'd0);
      send(8'h00);
      chk("t1_wen", {63'b0, bus.wen_ext}, 64'd1);
      chk("t1_wen2", {63'b0, bus.wen_ext_2}, 64'd0);
      chk("t1_addr", bus.addr_ext, 64'h8);
      chk("t1_wdata", {32'b0, bus.wdata_ext}, 64'h13);
      chk("t1_rdy_low", {63'b0, bus.rx_ready}, 64'd0);
      tick();
      chk("t1_wen_off", {63'b0, bus.wen_ext}, 64'd0);
      chk("t1_busy", {63'b0, bus.busy}, 64'd0);
      chk("t1_hold_addr", bus.addr_ext, 64'h8);
      chk("t1_count", 64'(imem_n - base_i), 64'd1);

      // two dmem words: N=2, S=0
      base_d = dmem_n;
      send(8'hA2);
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      for (int i = 0; i < 16; i++) begin
         send(d2[i]);
         if (i == 7 || i == 15) begin
            chk("t2_wen2", {63'b0, bus.wen_ext_2}, 64'd1);
            chk("t2_rdy_low", {63'b0, bus.rx_ready}, 64'd0);
         end
      end
      tick();
      chk("t2_busy", {63'b0, bus.busy}, 64'd0);
      chk("t2_count", 64'(dmem_n - base_d), 64'd2);
      chk("t2_addr0", d_addr[base_d], 64'h0);
      chk("t2_data0", d_data[base_d], 64'h8877665544332211);
      chk("t2_addr1", d_addr[base_d+1], 64'h8);
      chk("t2_data1", d_data[base_d+1], 64'h0807060504030201);

      // imem boundary: S=511, N=2; second word out of range
      base_i = imem_n;
      send(8'hA1);
      send(8'h02); send(8'h00); send(8'hFF); send(8'h01);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      chk("t3_err_clear", {63'b0, bus.err}, 64'd0);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("t3_suppressed", {63'b0, bus.wen_ext}, 64'd0);
      chk("t3_err", {63'b0, bus.err}, 64'd1);
      tick();
      chk("t3_idle", {63'b0, bus.busy}, 64'd0);
      chk("t3_count", 64'(imem_n - base_i), 64'd1);
      chk("t3_addr", i_addr[base_i], 64'h7FC);
      chk("t3_data", {32'b0, i_data[base_i]}, 64'hDDCCBBAA);
      send(8'hA5);
      chk("t3_clr_err", {63'b0, bus.err}, 64'd0);

      // run, then an empty load halts without writing
      send(8'hA3);
      chk("t4_run", {63'b0, bus.cpu_enable}, 64'd1);
      base_i = imem_n;
      send(8'hA1);
      chk("t4_halt", {63'b0, bus.cpu_enable}, 64'd0);
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      chk("t4_idle", {63'b0, bus.busy}, 64'd0);
      tick();
      chk("t4_nowrite", 64'(imem_n - base_i), 64'd0);
      send(8'hA3);
      send(8'hA4);
      chk("t4_halt_cmd", {63'b0, bus.cpu_enable}, 64'd0);

      // unknown command
      send(8'h55);
      chk("t5_err", {63'b0, bus.err}, 64'd1);
      chk("t5_idle", {63'b0, bus.busy}, 64'd0);
      send(8'hA5);
      chk("t5_clr", {63'b0, bus.err}, 64'd0);

      // reset mid-word, then a clean load
      send(8'h55);
      send(8'hA1);
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'h99); send(8'h88);
      chk("t6_pre_err", {63'b0, bus.err}, 64'd1);
      chk("t6_pre_busy", {63'b0, bus.busy}, 64'd1);
      @(negedge clk);
      arst = 1'b1;
      #1;
      chk("t6_err", {63'b0, bus.err}, 64'd0);
      chk("t6_rdy", {63'b0, bus.rx_ready}, 64'd0);
      chk("t6_busy", {63'b0, bus.busy}, 64'd0);
      chk("t6_cpu_en", {63'b0, bus.cpu_enable}, 64'd0);
      chk("t6_addr", bus.addr_ext, 64'd0);
      chk("t6_wdata", {32'b0, bus.wdata_ext}, 64'd0);
      chk("t6_addr2", bus.addr_ext_2, 64'd0);
      chk("t6_wdata2", bus.wdata_ext_2, 64'd0);
      @(negedge clk);
      arst = 1'b0;
      tick();
      chk("t6_rdy_up", {63'b0, bus.rx_ready}, 64'd1);
      send(8'hA1);
      send(8'h01); send(8'h00); send(8'h03); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("t6_wen", {63'b0, bus.wen_ext}, 64'd1);
      chk("t6_new_addr", bus.addr_ext, 64'hC);
      chk("t6_new_data", {32'b0, bus.wdata_ext}, 64'h04030201);
      tick();
      chk("t6_end_idle", {63'b0, bus.busy}, 64'd0);

      chk("strobe_rules", 64'(viol), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL provide parameter IMEM_WORDS, default 512, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL provide parameter DMEM_WORDS, default 1024, meaning data memory depth in 64-bit words.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; arst input 1 asynchronous active-high reset.
REQ-004 SHALL have these byte-stream input ports: rx_data input 8 (command/payload byte); rx_valid input 1 (byte present); rx_ready output 1 (loader accepts byte).
REQ-005 SHALL have these instruction-memory write ports: addr_ext output 64 (imem byte address); wen_ext output 1 (imem write strobe); ren_ext output 1 (tied 0); wdata_ext output 32 (imem write word).
REQ-006 SHALL have these data-memory write ports: addr_ext_2 output 64 (dmem byte address); wen_ext_2 output 1 (dmem write strobe); ren_ext_2 output 1 (tied 0); wdata_ext_2 output 64 (dmem write word).
REQ-007 SHALL have these status ports: cpu_enable output 1 (drives CPU enable); busy output 1 (state != IDLE); err output 1 (sticky error flag).

Function
REQ-008 SHALL accept a byte only when rx_valid && rx_ready are both high on a rising edge.
REQ-009 SHALL decode command bytes in IDLE: 0xA1 LOAD_I, 0xA2 LOAD_D, 0xA3 RUN, 0xA4 HALT, 0xA5 CLR_ERR.
REQ-010 SHALL set err on any other byte received in IDLE, discard that byte, and remain in IDLE.
REQ-011 SHALL set cpu_enable=1 on the cycle after accepting RUN, and SHALL clear cpu_enable on the cycle after accepting HALT, LOAD_I or LOAD_D.
REQ-012 SHALL follow LOAD_x with a 4-byte little-endian header: count[15:0] N, then start word index S[15:0] (state HDR).
REQ-013 SHALL return to IDLE after the header when N=0, with no write issued.
REQ-014 SHALL then receive N words, little-endian: 4 bytes per word for LOAD_I and 8 bytes per word for LOAD_D (state DATA).
REQ-015 SHALL enter WRITE after the last byte of each word, holding rx_ready=0 for that single cycle.
REQ-016 SHALL drive the selected wen high for exactly one cycle in WRITE, together with wdata and the byte address: S+k times 4 for imem, S+k times 8 for dmem, where k is the 0-based word index within the load.
REQ-017 SHALL issue the write strobe one cycle after the final byte of the word is accepted.
REQ-018 SHALL go from WRITE to DATA if words remain, else to IDLE.
REQ-019 SHALL compute the word index S+k at 17-bit width with no wrap-around.
REQ-020 SHALL suppress the write and set err when the word index is at or above the target depth, while still consuming that word's bytes.
REQ-021 SHALL keep rx_ready=1 in IDLE, HDR and DATA, and rx_ready=0 in WRITE.
REQ-022 SHALL hold both write strobes at 0 outside WRITE, and SHALL never assert wen_ext and wen_ext_2 in the same cycle.
REQ-023 SHALL keep err set until CLR_ERR or reset; CLR_ERR clears it on the cycle after acceptance.
REQ-024 SHALL hold addr_ext, wdata_ext, addr_ext_2 and wdata_ext_2 at their last values when not writing.

Reset
REQ-025 SHALL, on assertion of arst at any time, including mid-header or mid-word, force state IDLE, cpu_enable=0, err=0, wen_ext=0, wen_ext_2=0, rx_ready=0 while reset is asserted, all addresses and data to 0, and all counters to 0.
REQ-026 SHALL raise rx_ready on the first clk edge after arst deasserts, and SHALL discard any partial word received before the reset.

Structure
REQ-027 SHALL place the command codes (0xA1..0xA5), the state encoding (IDLE, HDR, DATA, WRITE) and the header length constant (4) in a shared loader package.
REQ-028 SHALL instantiate one sub-module, loader_shift_reg: a 64-bit little-endian byte assembler with load, shift and clear controls that is reused for both header and data bytes.

Verification
REQ-029 SHALL cover: A1, 01 00, 02 00, bytes 13 00 00 00 -> one-cycle wen_ext, addr_ext=0x8, wdata_ext=0x00000013, then busy=0.
REQ-030 SHALL cover: A2, 02 00, 00 00, 16 data bytes -> two wen_ext_2 pulses at addresses 0x0 and 0x8 with the correct 64-bit words, and rx_ready low during each write cycle.
REQ-031 SHALL cover: A1, 02 00, FF 01 (S=511), 8 bytes -> write at addr 0x7FC only, err=1, state IDLE afterwards.
REQ-032 SHALL cover: A3 -> cpu_enable=1; then A1, 00 00, 00 00 -> cpu_enable=0, no write, IDLE.
REQ-033 SHALL cover: byte 0x55 in IDLE -> err=1; then A5 -> err=0.
REQ-034 SHALL cover: arst pulsed after 2 of 4 data bytes -> all outputs reset; a subsequent clean LOAD_I writes correctly with no stale bytes.
